// File: rtl/conv_pkg.sv
// Shared convolution-layer definitions: lane geometry, widths, writer FSM states
// and the output-size rule used by both the read selector and the output writer.
package conv_pkg;

  localparam int unsigned LANES  = 5;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SIDE_W = 5;
  localparam int unsigned OSQ_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_FIN
  } state_e;

  // Job configuration latched on an accepted start
  typedef struct packed {
    logic [SIDE_W-1:0] osz;
    logic [OSQ_W-1:0]  osq;
    logic [SIDE_W-1:0] nk;
    logic              relu;
  } cfg_t;

  // Output side length; a partial final stride step still yields a column
  function automatic logic [SIDE_W-1:0] out_size(input logic [4:0] img,
                                                 input logic [2:0] k,
                                                 input logic [1:0] s);
    logic [5:0] num;
    num = 6'(img) - 6'(k) + 6'(s) - 6'd1;
    if (s == 2'd0) return '0;
    return SIDE_W'(num / 6'(s)) + SIDE_W'(1);
  endfunction

endpackage

// File: rtl/conv_sat_relu.sv
// Per-lane post-processing: arithmetic right shift, saturation to the pixel
// range, then optional clamp of negatives to zero.
module conv_sat_relu #(
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SHIFT  = 4
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic                     relu_en_i,
  output logic signed [DATA_W-1:0] pix_c_o
);

  localparam int MAX_I = (1 << (DATA_W - 1)) - 1;
  localparam int MIN_I = -(1 << (DATA_W - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(MIN_I);

  logic signed [ACC_W-1:0] sh_c;

  always_comb begin
    sh_c = acc_i >>> SHIFT;
    if (sh_c > MAX_V) begin
      pix_c_o = MAX_V[DATA_W-1:0];
    end else if (sh_c < MIN_V) begin
      pix_c_o = MIN_V[DATA_W-1:0];
    end else begin
      pix_c_o = sh_c[DATA_W-1:0];
    end
    if (relu_en_i && pix_c_o[DATA_W-1]) pix_c_o = '0;
  end

endmodule

// File: rtl/conv_output_writer.sv
// Accepts 5-lane result beats from the PE array and serializes the valid lanes
// into output feature-map RAM writes (kernel outer, strip middle, row inner).
module conv_output_writer #(
  parameter int unsigned ACC_W  = conv_pkg::ACC_W,
  parameter int unsigned DATA_W = conv_pkg::DATA_W,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned ADDR_W = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [4:0]                        img_size,
  input  logic [2:0]                        kernel_size,
  input  logic [1:0]                        stride,
  input  logic [4:0]                        number_kernel,
  input  logic                              relu_en,
  input  logic                              res_valid,
  output logic                              res_ready,
  input  logic [conv_pkg::LANES*ACC_W-1:0]  res_data,
  output logic                              wr_en,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic [DATA_W-1:0]                 wr_data,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_err
);

  import conv_pkg::*;

  localparam int unsigned HOLD_W = LANES * ACC_W;

  state_e                  state_q, state_d;
  cfg_t                    cfg_q, cfg_d;
  logic [SIDE_W-1:0]       row_q, row_d, cbase_q, cbase_d, kern_q, kern_d;
  logic [2:0]              lane_q, lane_d;
  logic [ADDR_W-1:0]       rbase_q, rbase_d, kbase_q, kbase_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    res_ready_q, res_ready_d, wr_en_q, wr_en_d;
  logic                    busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;

  logic                    cfg_bad_c, accept_c;
  logic [SIDE_W-1:0]       osz_c, cols_left_c;
  logic [2:0]              lanes_c;
  logic                    last_lane_c, last_row_c, last_strip_c, last_kern_c;
  logic signed [ACC_W-1:0] lane_acc_c;
  logic signed [DATA_W-1:0] pix_c;

  // Config legality and derived geometry of the current strip
  always_comb begin
    cfg_bad_c    = (5'(kernel_size) > img_size) || (stride == 2'd0) ||
                   ((kernel_size != 3'd3) && (kernel_size != 3'd5));
    osz_c        = out_size(img_size, kernel_size, stride);
    accept_c     = res_valid && res_ready_q;
    cols_left_c  = cfg_q.osz - cbase_q;
    lanes_c      = (cols_left_c >= SIDE_W'(LANES)) ? 3'(LANES) : 3'(cols_left_c);
    last_lane_c  = (lane_q == lanes_c - 3'd1);
    last_row_c   = (row_q == cfg_q.osz - SIDE_W'(1));
    last_strip_c = ((6'(cbase_q) + 6'(LANES)) >= 6'(cfg_q.osz));
    last_kern_c  = (kern_q == cfg_q.nk - SIDE_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cfg_bad_c) state_d = (number_kernel == 5'd0) ? ST_FIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (accept_c) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_lane_c)
          state_d = (last_row_c && last_strip_c && last_kern_c) ? ST_FIN : ST_WAIT;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter/config updates; outputs are computed from next-state values so the
  // registered write lands in the same cycle the FSM sits in WRITE.
  always_comb begin
    cfg_d     = cfg_q;
    row_d     = row_q;
    cbase_d   = cbase_q;
    kern_d    = kern_q;
    lane_d    = lane_q;
    rbase_d   = rbase_q;
    kbase_d   = kbase_q;
    hold_d    = hold_q;
    done_d    = done_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_err_d = cfg_bad_c;
          if (!cfg_bad_c) begin
            cfg_d.osz  = osz_c;
            cfg_d.osq  = OSQ_W'(OSQ_W'(osz_c) * OSQ_W'(osz_c));
            cfg_d.nk   = number_kernel;
            cfg_d.relu = relu_en;
            row_d      = '0;
            cbase_d    = '0;
            kern_d     = '0;
            lane_d     = '0;
            rbase_d    = '0;
            kbase_d    = '0;
            done_d     = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (accept_c) begin
          hold_d = res_data;
          lane_d = '0;
        end
      end
      ST_WRITE: begin
        if (!last_lane_c) begin
          lane_d = lane_q + 3'd1;
        end else begin
          lane_d = '0;
          if (!last_row_c) begin
            row_d   = row_q + SIDE_W'(1);
            rbase_d = rbase_q + ADDR_W'(cfg_q.osz);
          end else begin
            row_d   = '0;
            rbase_d = '0;
            if (!last_strip_c) begin
              cbase_d = cbase_q + SIDE_W'(LANES);
            end else begin
              cbase_d = '0;
              kern_d  = kern_q + SIDE_W'(1);
              kbase_d = kbase_q + ADDR_W'(cfg_q.osq);
            end
          end
        end
      end
      default: ;
    endcase

    lane_acc_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_d == 3'(i)) lane_acc_c = hold_d[i*ACC_W +: ACC_W];
    end

    if (state_d == ST_FIN) done_d = 1'b1;
    res_ready_d = (state_d == ST_WAIT);
    busy_d      = (state_d == ST_WAIT) || (state_d == ST_WRITE);
    wr_en_d     = (state_d == ST_WRITE);
    wr_addr_d   = kbase_d + rbase_d + ADDR_W'(cbase_d) + ADDR_W'(lane_d);
    wr_data_d   = pix_c;
  end

  conv_sat_relu #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .acc_i    (lane_acc_c),
    .relu_en_i(cfg_d.relu),
    .pix_c_o  (pix_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q       <= '0;
      row_q       <= '0;
      cbase_q     <= '0;
      kern_q      <= '0;
      lane_q      <= '0;
      rbase_q     <= '0;
      kbase_q     <= '0;
      hold_q      <= '0;
      res_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      row_q       <= row_d;
      cbase_q     <= cbase_d;
      kern_q      <= kern_d;
      lane_q      <= lane_d;
      rbase_q     <= rbase_d;
      kbase_q     <= kbase_d;
      hold_q      <= hold_d;
      res_ready_q <= res_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign res_ready = res_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv_output_writer.sv
// Scoreboard bench for conv_output_writer: expected RAM writes are derived from
// the output-map geometry and queued as beats are issued; a monitor pops them.
module tb_conv_output_writer;

  localparam int ACC_W  = 20;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 15;
  localparam int LANES  = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [4:0]               img_size;
  logic [2:0]               kernel_size;
  logic [1:0]               stride;
  logic [4:0]               number_kernel;
  logic                     relu_en;
  logic                     res_valid;
  logic                     res_ready;
  logic [LANES*ACC_W-1:0]   res_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     busy;
  logic                     done;
  logic                     cfg_err;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;
  int  wr_count = 0;
  bit  hold_mode = 1'b0;

  always #5 clk = ~clk;

  conv_output_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .img_size     (img_size),
    .kernel_size  (kernel_size),
    .stride       (stride),
    .number_kernel(number_kernel),
    .relu_en      (relu_en),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference pixel: floor divide by 16, clamp to signed 8 bits, optional ReLU
  function automatic int ref_pix(input int acc, input bit relu);
    int v;
    v = (acc >= 0) ? acc / 16 : -((-acc + 15) / 16);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  function automatic int gen_val(input int pattern, input int r, input int l);
    int pick[9];
    pick = '{524287, -524288, 4095, -4096, -16, 2047, 2032, 2048, -2049};
    case (pattern)
      0: return 16 * (r * 5 + l);
      2: begin
        case (l)
          0: return 4095;
          1: return -4096;
          2: return -16;
          3: return 112;
          default: return -17;
        endcase
      end
      default: begin
        case ($urandom_range(0, 2))
          0: return int'($urandom_range(0, 1048575)) - 524288;
          1: return int'($urandom_range(0, 4095)) - 2048;
          default: return pick[$urandom_range(0, 8)];
        endcase
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0d with empty scoreboard", wr_addr,
                 int'($signed(wr_data)));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(wr_addr), e.addr);
        check("wr_data", int'($signed(wr_data)), e.data);
      end
    end
  end

  task automatic do_start(input int img, input int k, input int s, input int n, input bit relu);
    @(negedge clk);
    img_size = 5'(img); kernel_size = 3'(k); stride = 2'(s);
    number_kernel = 5'(n); relu_en = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [LANES*ACC_W-1:0] d, input int nl, input bit last);
    int n;
    int low;
    if (!hold_mode) repeat ($urandom_range(0, 2)) @(negedge clk);
    res_valid = 1'b1;
    res_data  = d;
    n = 0;
    while (!res_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!res_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: res_ready %0d after %0d cycles, required 1", res_ready, n);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold_mode) res_valid = 1'b0;
    if (!last) begin
      low = 0;
      while (!res_ready && low < 20) begin
        low++;
        @(negedge clk);
      end
      check("ready_low_cycles", low, nl);
    end
  endtask

  task automatic run_job(input int img, input int k, input int s, input int n, input bit relu,
                         input int pattern);
    int osz, osq, strips, nl, cnt;
    logic [LANES*ACC_W-1:0] d;
    int v;
    osz    = (img - k) / s + (((img - k) % s) != 0 ? 1 : 0) + 1;
    osq    = osz * osz;
    strips = (osz + 4) / 5;
    do_start(img, k, s, n, relu);
    check("busy_after_start", int'(busy), 1);
    check("done_cleared", int'(done), 0);
    nl = 0;
    for (int kk = 0; kk < n; kk++) begin
      for (int st = 0; st < strips; st++) begin
        for (int r = 0; r < osz; r++) begin
          nl = (osz - 5 * st < 5) ? osz - 5 * st : 5;
          for (int l = 0; l < LANES; l++) begin
            v = gen_val(pattern, r, l);
            d[l*ACC_W +: ACC_W] = v[ACC_W-1:0];
            if (l < nl) exp_q.push_back('{kk * osq + r * osz + st * 5 + l, ref_pix(v, relu)});
          end
          send_beat(d, nl, (kk == n - 1) && (st == strips - 1) && (r == osz - 1));
        end
      end
    end
    cnt = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("done_latency", cnt, nl);
    check("pending_writes", exp_q.size(), 0);
    check("busy_at_done", int'(busy), 0);
    res_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_res_ready"}, int'(res_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cfg_err"}, int'(cfg_err), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
  endtask

  initial begin
    int base;
    int img, k, s;
    logic [LANES*ACC_W-1:0] d;
    int v;
    rst_n = 1'b0; start = 1'b0; img_size = '0; kernel_size = '0; stride = '0;
    number_kernel = '0; relu_en = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic 5x5 output, one kernel, ramp data
    run_job(7, 3, 1, 1, 1'b0, 0);

    // 11x11 output, two kernels: last strip has a single lane
    base = wr_count;
    run_job(13, 3, 1, 2, 1'b0, 0);
    check("job13_write_count", wr_count - base, 242);

    // Saturation corners without and with ReLU
    run_job(5, 3, 1, 1, 1'b0, 2);
    run_job(5, 3, 1, 1, 1'b1, 2);

    // Illegal configs
    do_start(4, 5, 1, 1, 1'b0);
    check("cfg_err_k_gt_img", int'(cfg_err), 1);
    check("cfg_err_busy", int'(busy), 0);
    do_start(10, 3, 0, 1, 1'b0);
    check("cfg_err_stride0", int'(cfg_err), 1);
    do_start(10, 4, 1, 1, 1'b0);
    check("cfg_err_k4", int'(cfg_err), 1);
    check("cfg_err_ready", int'(res_ready), 0);
    repeat (4) @(negedge clk);

    // Zero kernels: done on the cycle after start
    do_start(7, 3, 1, 0, 1'b0);
    check("n0_done", int'(done), 1);
    check("n0_cfg_err", int'(cfg_err), 0);
    check("n0_busy", int'(busy), 0);
    repeat (3) @(negedge clk);

    // Held-high valid
    hold_mode = 1'b1;
    run_job(9, 3, 2, 2, 1'b0, 1);
    hold_mode = 1'b0;

    // Reset in the middle of a WRITE phase
    do_start(7, 3, 1, 1, 1'b0);
    for (int l = 0; l < LANES; l++) begin
      v = gen_val(1, 0, l);
      d[l*ACC_W +: ACC_W] = v[ACC_W-1:0];
      exp_q.push_back('{l, ref_pix(v, 1'b0)});
    end
    res_valid = 1'b1;
    res_data  = d;
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_job(7, 3, 1, 1, 1'b1, 1);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      k   = ($urandom_range(0, 1) == 0) ? 3 : 5;
      img = $urandom_range(k, 18);
      s   = $urandom_range(1, 2);
      hold_mode = 1'($urandom_range(0, 1));
      run_job(img, k, s, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1);
    end
    hold_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/conv_output_writer.md
Name: conv_output_writer

Overview:
- Write-side counterpart of the input-RAM read selector in the convolution layer.
- Accepts one 5-lane beat of convolution results per output row per strip, from the PE array.
- Applies shift, saturation and optional ReLU to each lane, then serializes the valid lanes into single-port output feature-map RAM writes.
- Traversal order matches the read side: kernel outer, 5-column strip middle, output row inner.

Parameters:
- ACC_W, 20, signed accumulator width per lane.
- DATA_W, 8, signed output pixel width.
- SHIFT, 4, arithmetic right shift applied before saturation.
- ADDR_W, 15, output RAM address width.
- LANES, 5, lanes per beat (fixed 5; parameter for package use only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches config when idle.
- img_size  in  5  input image side.
- kernel_size  in  3  3 or 5.
- stride  in  2  1 or 2.
- number_kernel  in  5  number of output maps.
- relu_en  in  1  clamp negatives to 0.
- res_valid  in  1  beat valid.
- res_ready  out  1  writer can accept a beat.
- res_data  in  LANES*ACC_W  lane i at [i*ACC_W +: ACC_W]; lane 0 = leftmost column of the strip.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM word address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  job in progress.
- done  out  1  level; set when the last write is issued, cleared by the next accepted start.
- cfg_err  out  1  level; set on an illegal config, cleared by the next start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Derived on start:
  - out_size = ((img_size - kernel_size + stride - 1)/stride) + 1, matching the read-side column count.
  - out_sq = out_size*out_size.
  - Strips = ceil(out_size/5).
  - Lanes in strip s = min(5, out_size - 5*s).
- FSM states: IDLE, WAIT, WRITE, FIN.
- IDLE:
  - res_ready = 0.
  - On start:
    - kernel_size > img_size, stride = 0, or kernel_size not in {3,5} -> cfg_err = 1, stay IDLE.
    - number_kernel = 0 -> FIN.
    - Otherwise -> WAIT with busy = 1, done = 0, cfg_err = 0.
  - start while busy is ignored.
- WAIT:
  - res_ready = 1.
  - On res_valid & res_ready: capture res_data into the holding register; go to WRITE with lane = 0.
- WRITE (registered outputs, one RAM write per cycle):
  - Signals: wr_en = 1, wr_addr = kbase + rbase + cbase + lane, wr_data = f(lane value).
  - f: sign-extend, arithmetic shift right by SHIFT, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if relu_en, negatives become 0.
  - After lane = lanes-1, advance position:
    - Row: row++, rbase += out_size.
    - On row wrap: row = 0, rbase = 0, strip++, cbase += 5.
    - On strip wrap: strip = 0, cbase = 0, kernel++, kbase += out_sq.
    - Then go to WAIT, or FIN if that was the last lane of the last beat of the last kernel.
- Latency:
  - First write is in the cycle after acceptance.
  - Beat throughput = lanes + 1 cycles.
  - res_ready deasserts for the whole WRITE phase.
- Lanes beyond the strip's lane count are discarded and never written.
- FIN: done = 1, busy = 0, next state IDLE.
- Addresses are computed only with adders; no multipliers.
- Reset mid-job: immediate return to IDLE; the partial job is abandoned.

Decomposition:
- Shared package conv_pkg holds:
  - LANES = 5.
  - ACC_W, DATA_W.
  - FSM state enum.
  - out_size function, shared with the read selector.
- One sub-module: conv_sat_relu (combinational shift/saturate/ReLU, one instance on the muxed lane).

Test Plan:
- img 7, k 3, s 1, N 1, 5 beats of lanes 0..4 = 16*(row*5+lane) -> 25 writes, addr 0..24, data = row*5+lane; done after write 24.
- img 13, k 3, s 1 (out 11), N 2 -> strip 2 writes 1 lane per beat; kernel 1 strip 2 row 3 lane 0 at addr 164; 242 writes total.
- Saturation: lane = 4095 -> 127; lane = -4096 -> -128 with relu_en = 0, 0 with relu_en = 1; lane = -16 -> -1.
- Config errors: start with k 5, img 4 -> cfg_err = 1, no writes. Start with N 0 -> done = 1 next cycle, no writes.
- Handshake: res_valid held high throughout -> res_ready low for exactly lanes cycles after each accept; beats are never lost or duplicated.
- Assert rst_n low mid-WRITE, then restart -> all outputs 0 during reset; new job begins at addr 0.
